// File: rtl/sram22_march_bist_if.sv
// Single-port sram22 macro bus as seen from the BIST initiator (master) and the macro (slave).
interface sram22_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8
);
  logic                  sram_ce;
  logic                  sram_we;
  logic [DATA_WIDTH-1:0] sram_wmask;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_din;
  logic [DATA_WIDTH-1:0] sram_dout;

  modport master (
    output sram_ce, sram_we, sram_wmask, sram_addr, sram_din,
    input  sram_dout
  );

  modport slave (
    input  sram_ce, sram_we, sram_wmask, sram_addr, sram_din,
    output sram_dout
  );
endinterface

// File: rtl/sram22_march_bist.sv
// March C- BIST initiator for one sram22 macro: one op per cycle, 10*DEPTH ops, first-failure capture.
// Optional macro SRAM22_BIST_ERRCNT_EN adds err_cnt, a saturating count of mismatching reads.
module sram22_march_bist #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] bg,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [DATA_WIDTH-1:0] fail_bits,
`ifdef SRAM22_BIST_ERRCNT_EN
  output logic [15:0]           err_cnt,
`endif
  sram22_if.master              sram
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                state_q;
  logic                  busy_q, done_q, fail_q;
  logic [ADDR_WIDTH-1:0] fail_addr_q;
  logic [2:0]            fail_elem_q;
  logic [DATA_WIDTH-1:0] fail_bits_q;

  // Generator position: the operation to present at the next issuing edge.
  logic [2:0]            elem_q, elem_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wr_q, wr_d;
  logic                  last_q;
  logic [DATA_WIDTH-1:0] bg_q;

  logic                  ce_q, we_q;
  logic [DATA_WIDTH-1:0] wmask_q, din_q, exp_q;
  logic [ADDR_WIDTH-1:0] sram_addr_q;
  logic [2:0]            op_elem_q;

  logic                  rd_pend_q;
  logic [DATA_WIDTH-1:0] pend_exp_q;
  logic [ADDR_WIDTH-1:0] pend_addr_q;
  logic [2:0]            pend_elem_q;

  function automatic logic elem_desc(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] elem_first(input logic [2:0] e);
    return elem_desc(e) ? '1 : '0;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] elem_final(input logic [2:0] e);
    return elem_desc(e) ? '0 : '1;
  endfunction

  logic                  accept, issue, mismatch;
  logic [2:0]            op_elem;
  logic [ADDR_WIDTH-1:0] op_addr;
  logic                  op_wr, op_last;
  logic [DATA_WIDTH-1:0] op_bg, op_data;

  assign accept   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign issue    = accept || ((state_q == S_RUN) && !last_q);
  assign mismatch = rd_pend_q && (sram.sram_dout != pend_exp_q);

  // On the accepting edge the first op comes straight from constants and the live bg.
  always_comb begin
    op_elem = accept ? 3'd0 : elem_q;
    op_addr = accept ? '0 : addr_q;
    op_wr   = accept ? 1'b1 : wr_q;
    op_bg   = accept ? bg : bg_q;
    // Writes use pattern elem[0], reads use the opposite of it.
    op_data = ((op_wr ? op_elem[0] : ~op_elem[0]) == 1'b1) ? ~op_bg : op_bg;
    elem_d  = op_elem;
    addr_d  = op_addr;
    wr_d    = op_wr;
    op_last = 1'b0;
    if (!op_wr && (op_elem != 3'd5)) begin
      wr_d = 1'b1;
    end else if (op_addr == elem_final(op_elem)) begin
      if (op_elem == 3'd5) begin
        op_last = 1'b1;
      end else begin
        elem_d = op_elem + 3'd1;
        addr_d = elem_first(elem_d);
        wr_d   = 1'b0;
      end
    end else begin
      addr_d = elem_desc(op_elem) ? op_addr - 1'b1 : op_addr + 1'b1;
      wr_d   = (op_elem == 3'd0);
    end
  end

`ifdef SRAM22_BIST_ERRCNT_EN
  logic [15:0] err_cnt_q;
  always_ff @(posedge clk) begin
    if (!rstb) begin
      err_cnt_q <= '0;
    end else if (accept) begin
      err_cnt_q <= '0;
    end else if (mismatch && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end
  assign err_cnt = err_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      fail_bits_q <= '0;
      elem_q      <= '0;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      last_q      <= 1'b0;
      bg_q        <= '0;
      ce_q        <= 1'b0;
      we_q        <= 1'b0;
      wmask_q     <= '0;
      din_q       <= '0;
      exp_q       <= '0;
      sram_addr_q <= '0;
      op_elem_q   <= '0;
      rd_pend_q   <= 1'b0;
      pend_exp_q  <= '0;
      pend_addr_q <= '0;
      pend_elem_q <= '0;
    end else begin
      rd_pend_q   <= ce_q && !we_q;
      pend_exp_q  <= exp_q;
      pend_addr_q <= sram_addr_q;
      pend_elem_q <= op_elem_q;

      if (mismatch) begin
        fail_q <= 1'b1;
        if (!fail_q) begin
          fail_addr_q <= pend_addr_q;
          fail_elem_q <= pend_elem_q;
          fail_bits_q <= sram.sram_dout ^ pend_exp_q;
        end
      end

      if (issue) begin
        ce_q        <= 1'b1;
        we_q        <= op_wr;
        wmask_q     <= op_wr ? '1 : '0;
        din_q       <= op_wr ? op_data : '0;
        sram_addr_q <= op_addr;
        exp_q       <= op_data;
        op_elem_q   <= op_elem;
        elem_q      <= elem_d;
        addr_q      <= addr_d;
        wr_q        <= wr_d;
        last_q      <= op_last;
      end

      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q     <= S_RUN;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
            fail_bits_q <= '0;
            bg_q        <= bg;
          end
        end
        S_RUN: begin
          if (last_q) begin
            state_q <= S_DRAIN;
            ce_q    <= 1'b0;
            we_q    <= 1'b0;
            wmask_q <= '0;
            last_q  <= 1'b0;
          end
        end
        S_DRAIN: begin
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign fail            = fail_q;
  assign fail_addr       = fail_addr_q;
  assign fail_elem       = fail_elem_q;
  assign fail_bits       = fail_bits_q;
  assign sram.sram_ce    = ce_q;
  assign sram.sram_we    = we_q;
  assign sram.sram_wmask = wmask_q;
  assign sram.sram_addr  = sram_addr_q;
  assign sram.sram_din   = din_q;

endmodule
